// File: rtl/dpll_pkg.sv
// Shared types and helpers for the DPLL trim controller: trim width, state encoding,
// and the thermometer encoder used for the trim register.
package dpll_pkg;

  localparam int unsigned TRIM_W = 26;
  localparam int unsigned BC_W   = $clog2(TRIM_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    ADJ   = 2'd3
  } state_e;

  // Thermometer code: bit i is set when i < bc.
  function automatic logic [TRIM_W-1:0] therm(input logic [BC_W-1:0] bc);
    logic [TRIM_W-1:0] t;
    t = '0;
    for (int i = 0; i < int'(TRIM_W); i++) begin
      t[i] = (BC_W'(i) < bc);
    end
    return t;
  endfunction

endpackage

// File: rtl/dpll_ref_sync.sv
// Brings the asynchronous reference clock into the oscillator domain and flags
// its rising edge as a one-cycle pulse.
module dpll_ref_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic rise_c
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
    end
  end

  assign rise_c = sync_q[1] & ~prev_q;

endmodule

// File: rtl/dpll_trim_ctrl.sv
// Closed-loop trim controller for the ring oscillator: counts osc cycles per ref period
// and nudges the thermometer trim one step per period. Optional lock detect: DPLL_LOCK_DETECT_EN.
module dpll_trim_ctrl
  import dpll_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned INIT_BC = 13,
  parameter int unsigned LOCK_N  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              osc_ref,
  input  logic [DIV_W-1:0]  div,
  output logic [TRIM_W-1:0] trim,
  output logic [BC_W-1:0]   bcount,
  output logic [CNT_W-1:0]  meas,
  output logic              meas_vld,
  output logic              lock
);

  localparam int unsigned     CMP_W   = ((CNT_W > DIV_W) ? CNT_W : DIV_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(TRIM_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BC_W-1:0]    bcount_q, bc_d;
  logic [TRIM_W-1:0]  trim_q;
  logic [CNT_W-1:0]   meas_q, meas_d;
  logic               meas_vld_q, meas_vld_d;

  logic               ref_rise_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [CMP_W-1:0]   meas_x_c, div_x_c;
  logic               meas_gt_c, meas_lt_c;

  dpll_ref_sync u_ref_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (osc_ref),
    .rise_c  (ref_rise_c)
  );

  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign meas_x_c  = CMP_W'(meas_q);
  assign div_x_c   = CMP_W'(div);
  assign meas_gt_c = meas_x_c > div_x_c;
  assign meas_lt_c = meas_x_c < div_x_c;

  // A ref edge during ADJ is captured exactly like one seen in COUNT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bc_d       = bcount_q;
    meas_d     = meas_q;
    meas_vld_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (ref_rise_c) begin
            cnt_d   = CNT_W'(1);
            state_d = COUNT;
          end
        end
        COUNT, ADJ: begin
          cnt_d   = cnt_inc_c;
          state_d = COUNT;
          if (state_q == ADJ) begin
            if (meas_gt_c && (bcount_q != BC_MAX)) begin
              bc_d = bcount_q + BC_W'(1);
            end else if (meas_lt_c && (bcount_q != '0)) begin
              bc_d = bcount_q - BC_W'(1);
            end
          end
          if (ref_rise_c) begin
            meas_d     = cnt_q;
            cnt_d      = CNT_W'(1);
            meas_vld_d = 1'b1;
            state_d    = ADJ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bcount_q   <= BC_W'(INIT_BC);
      trim_q     <= therm(BC_W'(INIT_BC));
      meas_q     <= '0;
      meas_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcount_q   <= bc_d;
      trim_q     <= therm(bc_d);
      meas_q     <= meas_d;
      meas_vld_q <= meas_vld_d;
    end
  end

  assign trim     = trim_q;
  assign bcount   = bcount_q;
  assign meas     = meas_q;
  assign meas_vld = meas_vld_q;

`ifdef DPLL_LOCK_DETECT_EN
  localparam int unsigned     LK_W   = $clog2(LOCK_N + 1);
  localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_N);

  logic [LK_W-1:0]  streak_q, streak_d;
  logic             lock_q, lock_d;
  logic [CMP_W-1:0] diff_c;
  logic             in_band_c;

  assign diff_c    = meas_gt_c ? (meas_x_c - div_x_c) : (div_x_c - meas_x_c);
  assign in_band_c = diff_c <= CMP_W'(1);

  // Streak of consecutive in-band adjust cycles; one miss drops lock.
  always_comb begin
    streak_d = streak_q;
    lock_d   = lock_q;
    if (!enable) begin
      streak_d = '0;
      lock_d   = 1'b0;
    end else if (state_q == ADJ) begin
      if (in_band_c) begin
        if (streak_q != LK_MAX) begin
          streak_d = streak_q + LK_W'(1);
        end
        lock_d = (streak_d == LK_MAX);
      end else begin
        streak_d = '0;
        lock_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      streak_q <= '0;
      lock_q   <= 1'b0;
    end else begin
      streak_q <= streak_d;
      lock_q   <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_dpll_trim_ctrl.sv
// Scoreboard bench for dpll_trim_ctrl: ref periods are built from whole clock counts,
// expected meas/bcount/lock are queued per ref edge and checked on each meas_vld.
module tb_dpll_trim_ctrl;
  import dpll_pkg::*;

`ifdef DPLL_LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              enable;
  logic              osc_ref;
  logic [7:0]        div;
  logic [TRIM_W-1:0] trim;
  logic [BC_W-1:0]   bcount;
  logic [7:0]        meas;
  logic              meas_vld;
  logic              lock;

  dpll_trim_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .osc_ref  (osc_ref),
    .div      (div),
    .trim     (trim),
    .bcount   (bcount),
    .meas     (meas),
    .meas_vld (meas_vld),
    .lock     (lock)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int meas;
    int bc;
    bit lk;
  } exp_t;

  exp_t sb_q[$];
  exp_t pend_e;
  bit   pend;
  int   n_pass;
  int   n_total;
  int   m_bc;
  int   m_streak;

  function automatic logic [TRIM_W-1:0] exp_trim(input int bc);
    logic [63:0] one;
    one = 64'd1;
    return TRIM_W'((one << bc) - 64'd1);
  endfunction

  // Reference model of one adjust step, queued when the ref edge is driven.
  function automatic void push_meas(input int m);
    exp_t e;
    int   d;
    if (m > int'(div)) m_bc = (m_bc < 26) ? m_bc + 1 : 26;
    else if (m < int'(div)) m_bc = (m_bc > 0) ? m_bc - 1 : 0;
    d = m - int'(div);
    if (d <= 1 && d >= -1) m_streak = (m_streak < 4) ? m_streak + 1 : 4;
    else m_streak = 0;
    e.meas = m;
    e.bc   = m_bc;
    e.lk   = LOCK_EN && (m_streak >= 4);
    sb_q.push_back(e);
  endfunction

  // Scoreboard: meas on the meas_vld cycle, trim/bcount/lock one cycle later.
  always @(negedge clock) begin
    if (reset) begin
      sb_q.delete();
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        n_total++;
        if (bcount !== BC_W'(pend_e.bc)) $display("FAIL sb_bcount: got %0d expected %0d", bcount, pend_e.bc);
        else n_pass++;
        n_total++;
        if (trim !== exp_trim(pend_e.bc)) $display("FAIL sb_trim: got %h expected %h", trim, exp_trim(pend_e.bc));
        else n_pass++;
        n_total++;
        if (lock !== pend_e.lk) $display("FAIL sb_lock: got %b expected %b", lock, pend_e.lk);
        else n_pass++;
      end
      if (meas_vld === 1'b1) begin
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected_meas_vld: got meas_vld=1 expected none (meas=%0d)", meas);
        end else begin
          pend_e = sb_q.pop_front();
          pend   = 1'b1;
          if (meas !== 8'(pend_e.meas)) $display("FAIL sb_meas: got %0d expected %0d", meas, pend_e.meas);
          else n_pass++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // n ref periods of exactly 10 clocks; the first edge after arming yields no measurement.
  task automatic ref_edges(input int n, input bit arm, input int first_meas);
    for (int k = 0; k < n; k++) begin
      if (!(arm && k == 0)) push_meas((k == 0) ? first_meas : 10);
      osc_ref = 1'b1;
      tick(5);
      osc_ref = 1'b0;
      tick(5);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; osc_ref = 1'b0; div = 8'd10;
    tick(3);
    n_total++;
    if (bcount !== BC_W'(13)) $display("FAIL reset_bcount: got %0d expected 13", bcount);
    else n_pass++;
    n_total++;
    if (trim !== 26'h0001FFF) $display("FAIL reset_trim: got %h expected 0001fff", trim);
    else n_pass++;
    n_total++;
    if (meas !== 8'd0 || meas_vld !== 1'b0 || lock !== 1'b0)
      $display("FAIL reset_outputs: got meas=%0d vld=%b lock=%b expected 0/0/0", meas, meas_vld, lock);
    else n_pass++;
    reset = 1'b0; m_bc = 13; m_streak = 0;
    enable = 1'b1;
    ref_edges(6, 1'b1, 0);
    n_total++;
    if (bcount !== BC_W'(13) || lock !== LOCK_EN)
      $display("FAIL hold_div10: got bcount=%0d lock=%b expected 13/%b", bcount, lock, LOCK_EN);
    else n_pass++;
  endtask

  task automatic test_ramp_up;
    div = 8'd8;
    ref_edges(16, 1'b0, 10);
    n_total++;
    if (bcount !== BC_W'(26) || trim !== 26'h3FFFFFF)
      $display("FAIL ramp_up_sat: got bcount=%0d trim=%h expected 26/3ffffff", bcount, trim);
    else n_pass++;
  endtask

  task automatic test_ramp_down;
    div = 8'd12;
    ref_edges(29, 1'b0, 10);
    n_total++;
    if (bcount !== BC_W'(0) || trim !== 26'h0)
      $display("FAIL ramp_down_sat: got bcount=%0d trim=%h expected 0/0", bcount, trim);
    else n_pass++;
  endtask

  task automatic test_ref_missing;
    div = 8'd10;
    tick(266);
    ref_edges(5, 1'b0, 255);
    n_total++;
    if (bcount !== BC_W'(1) || lock !== LOCK_EN)
      $display("FAIL ref_missing: got bcount=%0d lock=%b expected 1/%b", bcount, lock, LOCK_EN);
    else n_pass++;
  endtask

  task automatic test_enable_drop;
    logic [TRIM_W-1:0] saved;
    saved = trim;
    enable = 1'b0;
    m_streak = 0;
    tick(20);
    n_total++;
    if (trim !== saved || lock !== 1'b0 || meas_vld !== 1'b0)
      $display("FAIL enable_drop: got trim=%h lock=%b vld=%b expected %h/0/0", trim, lock, meas_vld, saved);
    else n_pass++;
    enable = 1'b1;
    ref_edges(3, 1'b1, 0);
    n_total++;
    if (bcount !== BC_W'(1)) $display("FAIL reenable_bcount: got %0d expected 1", bcount);
    else n_pass++;
  endtask

  task automatic test_reset_mid_adj;
    bit found;
    found = 1'b0;
    osc_ref = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (meas_vld === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found) $display("FAIL adj_timeout: got no meas_vld in 20 clocks expected one");
    else n_pass++;
    reset = 1'b1;
    tick(1);
    n_total++;
    if (bcount !== BC_W'(13) || trim !== 26'h0001FFF)
      $display("FAIL mid_adj_reset_trim: got bcount=%0d trim=%h expected 13/0001fff", bcount, trim);
    else n_pass++;
    n_total++;
    if (meas !== 8'd0 || meas_vld !== 1'b0 || lock !== 1'b0)
      $display("FAIL mid_adj_reset_out: got meas=%0d vld=%b lock=%b expected 0/0/0", meas, meas_vld, lock);
    else n_pass++;
    n_total++;
    if (dut.state_q !== IDLE) $display("FAIL mid_adj_reset_state: got %0d expected IDLE", dut.state_q);
    else n_pass++;
    osc_ref = 1'b0;
    tick(1);
    reset = 1'b0; m_bc = 13; m_streak = 0;
    ref_edges(3, 1'b1, 0);
    n_total++;
    if (bcount !== BC_W'(13)) $display("FAIL restart_bcount: got %0d expected 13", bcount);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; pend = 1'b0;
    m_bc = 13; m_streak = 0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_ref_missing();
    test_enable_drop();
    test_reset_mid_adj();
    tick(5);
    n_total++;
    if (sb_q.size() != 0 || pend)
      $display("FAIL sb_drain: got %0d outstanding expected 0", sb_q.size() + int'(pend));
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
